// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register sequencer: mode codes, FSM states, count clamp.
package shift_pkg;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_SHR  = 2'b10;
  localparam logic [1:0] M_SHL  = 2'b11;

  localparam int unsigned MAX_CNT_DEFAULT = 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt, input logic [2:0] max_cnt);
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/shift_cnt_3bit.sv
// Loadable 3-bit down-counter with zero/one flags; saturates at zero.
module shift_cnt_3bit (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [2:0] i_val,
  output logic       o_zero,
  output logic       o_one
);

  logic [2:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_zero = (r_cnt == 3'd0);
  assign o_one  = (r_cnt == 3'd1);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for shift_reg_4bit: load, N shifts, done pulse; all outputs registered.
// Define SHIFT_SEQ_ROTATE_EN to feed q_in[0] back into si on right shifts (rotate).
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned MAX_CNT = MAX_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] word,
  input  logic       dir,
  input  logic [2:0] count,
  input  logic       ser_in,
  input  logic [3:0] q_in,
  output logic [1:0] M,
  output logic [3:0] D,
  output logic       si,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] MaxCntW = 3'(MAX_CNT);

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_word;
  logic       r_dir;
  logic [3:0] w_word_d;
  logic       w_dir_d;
  logic       w_accept;
  logic       w_cnt_zero;
  logic       w_cnt_one;
  logic       w_si_src;
  logic [1:0] w_m_d;
  logic [3:0] w_d_d;
  logic       w_si_d;
  logic       w_busy_d;
  logic       w_done_d;

  assign w_accept = (r_state == IDLE) && start;
  assign w_word_d = w_accept ? word : r_word;
  assign w_dir_d  = w_accept ? dir : r_dir;

  shift_cnt_3bit u_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_accept),
    .i_dec   (r_state == SHIFT),
    .i_val   (clamp_cnt(count, MaxCntW)),
    .o_zero  (w_cnt_zero),
    .o_one   (w_cnt_one)
  );

`ifdef SHIFT_SEQ_ROTATE_EN
  // si is registered, so predict Q[0] for the coming cycle: the loaded word's LSB
  // after LOAD, otherwise the bit that the current right shift moves into Q[0].
  assign w_si_src = (r_state == LOAD) ? r_word[0] : q_in[1];
  logic w_unused_ser;
  assign w_unused_ser = ser_in;
`else
  assign w_si_src = ser_in;
  logic w_unused_q;
  assign w_unused_q = ^q_in;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_d = LOAD;
      LOAD:    w_state_d = w_cnt_zero ? DONE : SHIFT;
      SHIFT:   if (w_cnt_one) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and captured on the same edge as the state.
  always_comb begin
    w_m_d    = M_HOLD;
    w_d_d    = 4'b0000;
    w_si_d   = 1'b0;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    unique case (w_state_d)
      IDLE: ;
      LOAD: begin
        w_m_d    = M_LOAD;
        w_d_d    = w_word_d;
        w_busy_d = 1'b1;
      end
      SHIFT: begin
        w_m_d    = w_dir_d ? M_SHL : M_SHR;
        w_si_d   = w_dir_d ? 1'b0 : w_si_src;
        w_busy_d = 1'b1;
      end
      DONE: begin
        w_done_d = 1'b1;
        w_busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_word  <= 4'b0000;
      r_dir   <= 1'b0;
      M       <= M_HOLD;
      D       <= 4'b0000;
      si      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_word  <= w_word_d;
      r_dir   <= w_dir_d;
      M       <= w_m_d;
      D       <= w_d_d;
      si      <= w_si_d;
      busy    <= w_busy_d;
      done    <= w_done_d;
    end
  end

endmodule
